tile_map_ctrl: RTL

- Owns the tile-map storage that feeds the sprite pixel generator.
- Each 32-bit word holds 8 four-bit sprite indices. The pixel generator presents a word index (current_tile) and receives the word (sprite_addr).
- Arbitrates between display reads and game-logic writes. Writes are queued and committed only while vde=0, so the map never changes mid-line.
- Provides a sequenced full-map clear.

---
 rtl/tile_map_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tile_map_ctrl.sv
// Tile-map storage for the sprite pixel generator. Display reads come straight out
// of the map. Host writes wait in a small queue and are committed only during blanking
// (vde=0). A sequenced clear fills every word with a chosen value.
module tile_map_ctrl #(
    parameter int N_WORDS    = 256,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vde,
    input  logic [ADDR_W-1:0] current_tile,
    output logic [31:0]       sprite_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              clr_req,
    input  logic [31:0]       clr_value,
    output logic              busy,
    output logic              clr_done,
    output logic              addr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W+1)'(N_WORDS);
    localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W+1)'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         mem_q [N_WORDS];
    logic [31:0]         mem_d [N_WORDS];
    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_addr_d [FIFO_DEPTH];
    logic [31:0]         fifo_data_q [FIFO_DEPTH];
    logic [31:0]         fifo_data_d [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [31:0]         clr_val_q, clr_val_d;
    logic [31:0]         sprite_q, sprite_d;
    logic                wr_ready_q, wr_ready_d;
    logic                err_q, err_d;

    logic                fifo_empty, fifo_full, full_next, push, pop;
    logic [ADDR_W-1:0]   pop_addr;
    logic [31:0]         pop_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push       = wr_valid && wr_ready_q;
    assign pop        = !vde && !fifo_empty && (state_q == IDLE || state_q == DRAIN);
    assign pop_addr   = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
    assign pop_data   = fifo_data_q[rd_ptr_q[PTR_W-1:0]];

    assign sprite_addr = sprite_q;
    assign wr_ready    = wr_ready_q;
    assign busy        = !fifo_empty || (state_q != IDLE);
    assign clr_done    = (state_q == DONE);
    assign addr_err    = err_q;

    // Next-state logic: display read, queue push/commit, and the clear sequencer.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        clr_val_d   = clr_val_q;
        err_d       = err_q;

        // The read uses the pre-write map, so a same-cycle commit returns old data.
        sprite_d = ({1'b0, current_tile} < WORD_LIMIT) ? mem_q[current_tile] : '0;

        if (pop) begin
            if ({1'b0, pop_addr} < WORD_LIMIT) begin
                mem_d[pop_addr] = pop_data;
            end else begin
                err_d = 1'b1;
            end
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push) begin
            fifo_addr_d[wr_ptr_q[PTR_W-1:0]] = wr_addr;
            fifo_data_d[wr_ptr_q[PTR_W-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (clr_req) begin
                    clr_val_d = clr_value;
                    // A push landing this same cycle must also commit ahead of the clear.
                    state_d = (!fifo_empty || push) ? DRAIN : CLEAR;
                end
            end
            DRAIN: begin
                idx_d = '0;
                if (fifo_empty) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!vde) begin
                    mem_d[idx_q[ADDR_W-1:0]] = clr_val_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        full_next  = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                     (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
        wr_ready_d = !full_next && (state_d == IDLE);
    end

    // State, map and queue registers; reset wipes the map and aborts any clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_q       <= '{default: '0};
            fifo_addr_q <= '{default: '0};
            fifo_data_q <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            idx_q       <= '0;
            clr_val_q   <= '0;
            sprite_q    <= '0;
            wr_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            clr_val_q   <= clr_val_d;
            sprite_q    <= sprite_d;
            wr_ready_q  <= wr_ready_d;
            err_q       <= err_d;
        end
    end

endmodule
